// File: rtl/rgb_expand_fade.sv
// RGB expander (IN_BITS -> OUT_BITS per channel, MSB-first replication) with
// frame-synchronous global fade. Optional colour-key compare under RGB_EXPAND_KEY_EN.
module rgb_expand_fade #(
  parameter int unsigned IN_BITS    = 1,
  parameter int unsigned OUT_BITS   = 6,
  parameter int unsigned LEVEL_BITS = 4,
  parameter int unsigned FADE_DIV   = 2,
  parameter int unsigned FADE_STEP  = 1,
  parameter int unsigned RESET_ON   = 1
) (
  input  logic                    clk,
  input  logic                    nReset,
  input  logic [3*IN_BITS-1:0]    pix_in,
  input  logic                    pix_valid_in,
  input  logic                    frame_tick,
  input  logic                    fade_in_req,
  input  logic                    fade_out_req,
`ifdef RGB_EXPAND_KEY_EN
  input  logic [3*IN_BITS-1:0]    key_colour,
  output logic                    key_out,
`endif
  output logic [3*OUT_BITS-1:0]   pix_out,
  output logic                    pix_valid_out,
  output logic [LEVEL_BITS:0]     level,
  output logic                    fade_busy
);

  localparam int unsigned LW    = LEVEL_BITS + 1;
  localparam int unsigned PW    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam int unsigned PRODW = OUT_BITS + LW;

  localparam logic [LW-1:0] LEVEL_MAX = LW'(1) << LEVEL_BITS;
  localparam logic [LW-1:0] LEVEL_RST = (RESET_ON != 0) ? LEVEL_MAX : '0;
  localparam logic [LW-1:0] STEP      = LW'(FADE_STEP);
  localparam logic [PW-1:0] DIV_LAST  = PW'(FADE_DIV - 1);

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_ON        = 2'd1,
    ST_FADE_UP   = 2'd2,
    ST_FADE_DOWN = 2'd3
  } state_t;

  localparam state_t ST_RST = (RESET_ON != 0) ? ST_ON : ST_OFF;

  state_t          state_q, state_d;
  logic [LW-1:0]   level_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [LW:0]     up_sum;
  logic            take_out, take_in, fading;

  // Next-state: fade_out wins over fade_in; a taken request swallows a same-cycle tick
  always_comb begin
    state_d  = state_q;
    level_d  = level;
    presc_d  = presc_q;
    up_sum   = {1'b0, level} + {1'b0, STEP};
    fading   = (state_q == ST_FADE_UP) || (state_q == ST_FADE_DOWN);
    take_out = fade_out_req && ((state_q == ST_ON) || (state_q == ST_FADE_UP));
    take_in  = !fade_out_req && fade_in_req &&
               ((state_q == ST_OFF) || (state_q == ST_FADE_DOWN));

    if (take_out) begin
      state_d = ST_FADE_DOWN;
      presc_d = '0;
    end else if (take_in) begin
      state_d = ST_FADE_UP;
      presc_d = '0;
    end else if (frame_tick && fading) begin
      if (presc_q == DIV_LAST) begin
        presc_d = '0;
        if (state_q == ST_FADE_UP) begin
          if (up_sum >= {1'b0, LEVEL_MAX}) begin
            level_d = LEVEL_MAX;
            state_d = ST_ON;
          end else begin
            level_d = up_sum[LW-1:0];
          end
        end else begin
          if (level <= STEP) begin
            level_d = '0;
            state_d = ST_OFF;
          end else begin
            level_d = level - STEP;
          end
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= ST_RST;
      level     <= LEVEL_RST;
      presc_q   <= '0;
      fade_busy <= 1'b0;
    end else begin
      state_q   <= state_d;
      level     <= level_d;
      presc_q   <= presc_d;
      fade_busy <= (state_d == ST_FADE_UP) || (state_d == ST_FADE_DOWN);
    end
  end

  function automatic logic [OUT_BITS-1:0] expand(input logic [IN_BITS-1:0] c);
    logic [OUT_BITS-1:0] e;
    e = '0;
    for (int k = 0; k < OUT_BITS; k++) begin
      e[OUT_BITS-1-k] = c[IN_BITS-1-(k % IN_BITS)];
    end
    return e;
  endfunction

  logic [3*OUT_BITS-1:0] exp_c;
  logic [3*OUT_BITS-1:0] s1_pix;
  logic [LW-1:0]         s1_lvl;
  logic                  s1_valid;
  logic [PRODW-1:0]      prod_c [3];
  logic [3*OUT_BITS-1:0] scaled_c;

  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      exp_c[ch*OUT_BITS +: OUT_BITS] = expand(pix_in[ch*IN_BITS +: IN_BITS]);
    end
  end

  // Full-width product; dropping LEVEL_BITS LSBs makes full level an exact identity
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      prod_c[ch] = PRODW'(s1_pix[ch*OUT_BITS +: OUT_BITS]) * PRODW'(s1_lvl);
      scaled_c[ch*OUT_BITS +: OUT_BITS] = prod_c[ch][LEVEL_BITS +: OUT_BITS];
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      s1_pix        <= '0;
      s1_lvl        <= '0;
      s1_valid      <= 1'b0;
      pix_out       <= '0;
      pix_valid_out <= 1'b0;
    end else begin
      s1_valid      <= pix_valid_in;
      pix_valid_out <= s1_valid;
      if (pix_valid_in) begin
        s1_pix <= exp_c;
        s1_lvl <= level;
      end
      if (s1_valid) begin
        pix_out <= scaled_c;
      end
    end
  end

`ifdef RGB_EXPAND_KEY_EN
  logic s1_key;

  // Key matches on the raw input code, before expansion
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      s1_key  <= 1'b0;
      key_out <= 1'b0;
    end else begin
      s1_key  <= pix_valid_in && (pix_in == key_colour);
      key_out <= s1_key;
    end
  end
`endif

endmodule

// File: tb/tb_rgb_expand_fade.sv
// Bench for rgb_expand_fade: scoreboard-checked pixel stream, fade FSM sequences,
// async reset, a 2->6 bit instance, and key compare when RGB_EXPAND_KEY_EN is set.
module tb_rgb_expand_fade;

  logic        clk = 1'b0;
  logic        nReset;
  logic [2:0]  pix_in;
  logic        pix_valid_in;
  logic        frame_tick, fade_in_req, fade_out_req;
  logic [17:0] pix_out;
  logic        pix_valid_out;
  logic [4:0]  level;
  logic        fade_busy;

  logic [5:0]  pix_in2;
  logic        pix_valid_in2;
  logic [17:0] pix_out2;
  logic        pix_valid_out2;
  logic [4:0]  level2;
  logic        fade_busy2;
  logic        zero = 1'b0;

  logic [2:0]  key_ref = 3'b010;
`ifdef RGB_EXPAND_KEY_EN
  logic        key_out, key_out2;
  logic [5:0]  key_colour2 = 6'b000000;
`endif

  always #5 clk = ~clk;

  rgb_expand_fade u_dut (
    .clk           (clk),
    .nReset        (nReset),
    .pix_in        (pix_in),
    .pix_valid_in  (pix_valid_in),
    .frame_tick    (frame_tick),
    .fade_in_req   (fade_in_req),
    .fade_out_req  (fade_out_req),
`ifdef RGB_EXPAND_KEY_EN
    .key_colour    (key_ref),
    .key_out       (key_out),
`endif
    .pix_out       (pix_out),
    .pix_valid_out (pix_valid_out),
    .level         (level),
    .fade_busy     (fade_busy)
  );

  rgb_expand_fade #(.IN_BITS(2), .OUT_BITS(6)) u_dut2 (
    .clk           (clk),
    .nReset        (nReset),
    .pix_in        (pix_in2),
    .pix_valid_in  (pix_valid_in2),
    .frame_tick    (zero),
    .fade_in_req   (zero),
    .fade_out_req  (zero),
`ifdef RGB_EXPAND_KEY_EN
    .key_colour    (key_colour2),
    .key_out       (key_out2),
`endif
    .pix_out       (pix_out2),
    .pix_valid_out (pix_valid_out2),
    .level         (level2),
    .fade_busy     (fade_busy2)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int exp_lvl;
  bit sb_en = 1'b0;

  typedef struct {
    logic [17:0] pix;
    int          stamp;
    logic        key;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [2:0]  pix;
    logic [17:0] exp;
  } vec_t;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent reference: 1-bit channel expands to 0 or 63, scaled by integer division
  function automatic logic [17:0] model(input logic [2:0] p, input int lvl);
    logic [17:0] r;
    int e;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      e = p[c] ? 63 : 0;
      r[c*6 +: 6] = 6'((e * lvl) / 16);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (sb_en && nReset && pix_valid_out) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: pix_valid_out=1 with nothing in flight");
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pix_out", 32'(pix_out), 32'(e.pix));
        check("latency", 32'(cyc - e.stamp), 32'd2);
`ifdef RGB_EXPAND_KEY_EN
        check("key_out", 32'(key_out), 32'(e.key));
`endif
      end
    end
  end

  task automatic drive(input logic [2:0] p, input logic v, input logic [17:0] exp);
    exp_t e;
    @(posedge clk); #1;
    pix_in       = p;
    pix_valid_in = v;
    if (v && sb_en) begin
      e.pix   = exp;
      e.stamp = cyc;
      e.key   = (p == key_ref);
      q.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(q.size()), 32'd0);
    @(negedge clk);
    check("valid_idle", 32'(pix_valid_out), 32'd0);
  endtask

  task automatic pulse(input logic o, input logic i, input logic t);
    @(posedge clk); #1;
    fade_out_req = o;
    fade_in_req  = i;
    frame_tick   = t;
    @(posedge clk); #1;
    fade_out_req = 1'b0;
    fade_in_req  = 1'b0;
    frame_tick   = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b1);
  endtask

  task automatic dut2_pix(input logic [5:0] p, input logic [17:0] exp);
    @(posedge clk); #1;
    pix_in2       = p;
    pix_valid_in2 = 1'b1;
    @(posedge clk); #1;
    pix_valid_in2 = 1'b0;
    @(negedge clk);
    check("dut2_valid_early", 32'(pix_valid_out2), 32'd0);
    @(negedge clk);
    check("dut2_valid", 32'(pix_valid_out2), 32'd1);
    check("dut2_pix", 32'(pix_out2), 32'(exp));
    @(negedge clk);
    check("dut2_valid_pulse", 32'(pix_valid_out2), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{3'b101, 18'h3F03F};
    vecs[1] = '{3'b111, 18'h3FFFF};
    vecs[2] = '{3'b000, 18'h00000};
    vecs[3] = '{3'b010, 18'h00FC0};
    vecs[4] = '{3'b110, 18'h3FFC0};
    vecs[5] = '{3'b001, 18'h0003F};
    vecs[6] = '{3'b100, 18'h3F000};

    nReset = 1'b0;
    pix_in = 3'b101; pix_valid_in = 1'b1;
    frame_tick = 1'b0; fade_in_req = 1'b0; fade_out_req = 1'b0;
    pix_in2 = '0; pix_valid_in2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pix_out", 32'(pix_out), 32'd0);
    check("rst_valid", 32'(pix_valid_out), 32'd0);
    check("rst_level", 32'(level), 32'd16);
    check("rst_busy", 32'(fade_busy), 32'd0);
    check("rst_level2", 32'(level2), 32'd16);
    pix_valid_in = 1'b0;
    #3 nReset = 1'b1;
    sb_en   = 1'b1;
    exp_lvl = 16;

    // Full-level table, back-to-back with one idle gap, then a single-cycle pulse
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].pix, 1'b1, vecs[i].exp);
      if (i == 3) drive(3'b000, 1'b0, 18'h0);
    end
    drive(3'b000, 1'b0, 18'h0);
    drain();
    drive(3'b101, 1'b1, 18'h3F03F);
    drive(3'b000, 1'b0, 18'h0);
    drain();

    // Fade out: two ticks per step
    pulse(1'b1, 1'b0, 1'b0);
    check("fo_busy", 32'(fade_busy), 32'd1);
    check("fo_level_start", 32'(level), 32'd16);
    ticks(2);
    check("fo_level_15", 32'(level), 32'd15);
    exp_lvl = 15;
    drive(3'b111, 1'b1, model(3'b111, exp_lvl));
    drive(3'b000, 1'b0, 18'h0);
    drain();
    check("scaled_59", 32'(pix_out), 32'h3BEFB);
    ticks(30);
    check("fo_level_0", 32'(level), 32'd0);
    check("fo_busy_done", 32'(fade_busy), 32'd0);
    exp_lvl = 0;
    drive(3'b111, 1'b1, model(3'b111, exp_lvl));
    drive(3'b000, 1'b0, 18'h0);
    drain();
    check("black_pix", 32'(pix_out), 32'd0);

    // Fade back in, then reversal mid-fade
    pulse(1'b0, 1'b1, 1'b0);
    check("fi_busy", 32'(fade_busy), 32'd1);
    ticks(32);
    check("fi_level_16", 32'(level), 32'd16);
    check("fi_busy_done", 32'(fade_busy), 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    ticks(6);
    check("rev_level_13", 32'(level), 32'd13);
    pulse(1'b0, 1'b1, 1'b0);
    ticks(2);
    check("rev_level_14", 32'(level), 32'd14);
    check("rev_busy", 32'(fade_busy), 32'd1);
    ticks(4);
    check("rev_level_16", 32'(level), 32'd16);
    check("rev_busy_done", 32'(fade_busy), 32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    check("fi_on_ignored", 32'(fade_busy), 32'd0);

    // Simultaneous requests: fade_out wins
    pulse(1'b1, 1'b1, 1'b0);
    check("both_busy", 32'(fade_busy), 32'd1);
    ticks(2);
    check("both_down_15", 32'(level), 32'd15);

    // Request with a same-cycle tick: tick dropped, prescaler cleared
    ticks(1);
    pulse(1'b0, 1'b1, 1'b1);
    check("reqtick_level", 32'(level), 32'd15);
    ticks(1);
    check("reqtick_presc", 32'(level), 32'd15);
    ticks(1);
    check("reqtick_up_16", 32'(level), 32'd16);
    check("reqtick_busy", 32'(fade_busy), 32'd0);

    // Async reset between edges, mid-fade, with pixels in flight
    pulse(1'b1, 1'b0, 1'b0);
    ticks(3);
    check("prerst_level", 32'(level), 32'd15);
    sb_en = 1'b0;
    drive(3'b111, 1'b1, 18'h0);
    drive(3'b101, 1'b1, 18'h0);
    drive(3'b110, 1'b1, 18'h0);
    #3 nReset = 1'b0;
    #1;
    check("arst_valid", 32'(pix_valid_out), 32'd0);
    check("arst_pix", 32'(pix_out), 32'd0);
    check("arst_level", 32'(level), 32'd16);
    check("arst_busy", 32'(fade_busy), 32'd0);
    pix_valid_in = 1'b0;
    q.delete();
    #2 nReset = 1'b1;
    sb_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("arst_no_valid", 32'(pix_valid_out), 32'd0);
    end
    exp_lvl = 16;
    drive(3'b110, 1'b1, 18'h3FFC0);
    drive(3'b000, 1'b0, 18'h0);
    drain();

    // Key stream (key outputs checked by the scoreboard when enabled)
    drive(3'b010, 1'b1, 18'h00FC0);
    drive(3'b011, 1'b1, 18'h00FFF);
    drive(3'b010, 1'b1, 18'h00FC0);
    drive(3'b000, 1'b0, 18'h0);
    drain();

    // 2-bit input instance
    dut2_pix({2'b10, 2'b01, 2'b11}, {6'b101010, 6'b010101, 6'b111111});
    dut2_pix({2'b00, 2'b11, 2'b01}, {6'b000000, 6'b111111, 6'b010101});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
